lcd_frame_seq: RTL and testbench
================================

Name: lcd_frame_seq

Overview:
- Upstream producer for the LCD driver: generates the 9-bit {rs, data} word stream over its ready/valid input.
- After reset: waits out the LCD power-up time, then issues the fixed HD44780 8-bit init sequence.
- Then refreshes a 2x16 character display continuously from an internal 32-byte frame buffer.
- Host logic writes characters into the buffer through a simple write port; it never touches the LCD protocol.

Parameters:
- POWERUP_CYCLES, 4000000, clk_i cycles to wait after reset before the first word (40 ms @ 100 MHz); benches override it to a small value.
- INIT_WORDS, 6, number of init words issued; fixed table, not user-extensible.

Ports:
- clk_i  input  1  system clock @ 100 MHz
- rst_n_i  input  1  reset; asynchronous assert, active low
- wr_en_i  input  1  frame-buffer write strobe
- wr_addr_i  input  5  buffer address; 0-15 = line 1, 16-31 = line 2
- wr_data_i  input  8  ASCII character to store
- data_o  output  9  word to driver: bit 8 = rs, bits 7:0 = data/instruction
- data_valid_o  output  1  data_o is valid
- device_ready_i  input  1  driver ready to accept a word
- init_done_o  output  1  high once the init sequence has been fully transferred
- frame_done_o  output  1  one-cycle pulse on transfer of the last character (address 31) of each refresh pass

Behaviour:
- Reset (async, rst_n_i=0):
  - data_o=9'h000, data_valid_o=0, init_done_o=0, frame_done_o=0.
  - All 32 buffer bytes = 8'h20 (space).
  - Power-up counter cleared; FSM = PWRUP.
- Transfer rule:
  - A word transfers at a rising edge where data_valid_o=1 and device_ready_i=1.
  - While valid and not ready, data_o and data_valid_o hold stable.
  - On the transfer edge, the next word is loaded into data_o and data_valid_o stays 1, so there are no bubbles except in PWRUP.
- FSM states:
  - PWRUP: valid=0; counter increments each cycle. When counter = POWERUP_CYCLES-1, load init word 0, set valid=1, go to INIT.
  - INIT: words in order 9'h038, 9'h038, 9'h038, 9'h00C, 9'h001, 9'h006. On transfer of the last word, set init_done_o=1, load 9'h080, go to ADDR1.
  - ADDR1: on transfer, load 9'h100|buf[0], go to LINE1.
  - LINE1: chars buf[0..15] as {1'b1, byte}, 5-bit char index incremented per transfer. On transfer of index 15, load 9'h0C0, go to ADDR2.
  - ADDR2: on transfer, load 9'h100|buf[16], go to LINE2.
  - LINE2: chars buf[16..31]. On transfer of index 31, pulse frame_done_o (1 cycle, the cycle after that edge), load 9'h080, go to ADDR1. Index wraps 31 -> 0.
- init_done_o stays 1 until reset.
- Buffer write:
  - wr_en_i=1 writes wr_data_i to buf[wr_addr_i] at the rising edge. Writes are accepted in every state, including PWRUP and INIT, and need no handshake.
  - Same-edge write and load of the same address: the load uses the old byte (read-before-write); the new byte appears on the next pass.
  - A write to an address already sent in the current pass appears on the next pass.
- device_ready_i held low indefinitely: the block stalls with the word held; no timeout.
- Reset asserted mid-word: outputs return to reset values immediately (asynchronous) and the buffer is re-cleared. After release, the full power-up wait and init sequence repeat.
- Counter width: 32 bits, compared against POWERUP_CYCLES-1. POWERUP_CYCLES=1 means valid asserts on the first edge after reset release.

Test Plan:
- Reset values: POWERUP_CYCLES=20, hold reset, then release -> data_valid_o=0 for exactly 19 cycles; valid=1 with data_o=9'h038 from the 20th edge.
- Init order with device_ready_i=1 constantly -> six transfers 038,038,038,00C,001,006. init_done_o rises on the edge of the 6th transfer, and the next word is 9'h080.
- Default refresh: no writes -> 080, sixteen 120, 0C0, sixteen 120, then 080 again. frame_done_o pulses once per pass, 34 transfers apart.
- Backpressure: drop device_ready_i for 10 cycles while data_o=9'h0C0 -> data_o and valid hold for all 10 cycles, and transfer occurs on the first edge with ready high.
- Buffer write: write 8'h41 to address 0 and 8'h5A to address 31 during INIT -> first pass shows 141 as the first char and 15A as the last. Then write 8'h42 to address 0 on the same edge its load occurs -> that pass shows 141, the next pass 142.
- Mid-operation reset: assert rst_n_i=0 while in LINE2 with valid high -> valid=0 and init_done_o=0 with no clock edge needed. After release, buffer reads back as all 120, and the full power-up/init sequence repeats.

Source files
------------

// File: rtl/lcd_frame_seq_if.sv
// Word stream from the frame sequencer to the LCD driver: 9-bit {rs, data} with ready/valid.
interface lcd_frame_seq_if;
   logic [8:0] data;
   logic       data_valid;
   logic       device_ready;

   modport master (
      output data,
      output data_valid,
      input  device_ready
   );

   modport slave (
      input  data,
      input  data_valid,
      output device_ready
   );
endinterface

// File: rtl/lcd_frame_seq.sv
// HD44780 frame sequencer: power-up wait, fixed 8-bit init, then endless 2x16 refresh
// from a host-writable 32-byte frame buffer.
module lcd_frame_seq #(
   parameter int unsigned POWERUP_CYCLES = 4000000,
   parameter int unsigned INIT_WORDS     = 6
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic                   wr_en_i,
   input  logic [4:0]             wr_addr_i,
   input  logic [7:0]             wr_data_i,
   lcd_frame_seq_if.master        lcd,
   output logic                   init_done_o,
   output logic                   frame_done_o
);

   typedef enum logic [2:0] {StPwrup, StInit, StAddr1, StLine1, StAddr2, StLine2} state_e;

   localparam logic [2:0]  LastInit = 3'(INIT_WORDS - 1);
   localparam logic [31:0] PwrLast  = 32'(POWERUP_CYCLES - 1);

   state_e      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [2:0]  init_idx_q, init_idx_d;
   logic [4:0]  chr_idx_q, chr_idx_d;
   logic [8:0]  data_q, data_d;
   logic        valid_q, valid_d;
   logic        init_done_q, init_done_d;
   logic        frame_done_q, frame_done_d;
   logic [7:0]  buf_q [32];
   logic        xfer;
   logic [4:0]  chr_next;

   function automatic logic [8:0] init_word(input logic [2:0] idx);
      case (idx)
         3'd0, 3'd1, 3'd2: init_word = 9'h038;
         3'd3:             init_word = 9'h00C;
         3'd4:             init_word = 9'h001;
         default:          init_word = 9'h006;
      endcase
   endfunction

   assign xfer     = valid_q & lcd.device_ready;
   assign chr_next = chr_idx_q + 5'd1;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= StPwrup;
         cnt_q        <= '0;
         init_idx_q   <= '0;
         chr_idx_q    <= '0;
         data_q       <= '0;
         valid_q      <= 1'b0;
         init_done_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         init_idx_q   <= init_idx_d;
         chr_idx_q    <= chr_idx_d;
         data_q       <= data_d;
         valid_q      <= valid_d;
         init_done_q  <= init_done_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Loads read buf_q before this edge's write lands, so a same-edge write shows next pass.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < 32; i++) buf_q[i] <= 8'h20;
      end else if (wr_en_i) begin
         buf_q[wr_addr_i] <= wr_data_i;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StPwrup: if (cnt_q == PwrLast) state_d = StInit;
         StInit:  if (xfer && init_idx_q == LastInit) state_d = StAddr1;
         StAddr1: if (xfer) state_d = StLine1;
         StLine1: if (xfer && chr_idx_q == 5'd15) state_d = StAddr2;
         StAddr2: if (xfer) state_d = StLine2;
         StLine2: if (xfer && chr_idx_q == 5'd31) state_d = StAddr1;
         default: state_d = StPwrup;
      endcase
   end

   always_comb begin
      cnt_d        = cnt_q;
      init_idx_d   = init_idx_q;
      chr_idx_d    = chr_idx_q;
      data_d       = data_q;
      valid_d      = valid_q;
      init_done_d  = init_done_q;
      frame_done_d = 1'b0;
      unique case (state_q)
         StPwrup: begin
            cnt_d = cnt_q + 32'd1;
            if (cnt_q == PwrLast) begin
               data_d     = init_word(3'd0);
               valid_d    = 1'b1;
               init_idx_d = 3'd0;
            end
         end
         StInit: if (xfer) begin
            if (init_idx_q == LastInit) begin
               init_done_d = 1'b1;
               data_d      = 9'h080;
            end else begin
               init_idx_d = init_idx_q + 3'd1;
               data_d     = init_word(init_idx_q + 3'd1);
            end
         end
         StAddr1: if (xfer) begin
            chr_idx_d = 5'd0;
            data_d    = {1'b1, buf_q[0]};
         end
         StLine1: if (xfer) begin
            if (chr_idx_q == 5'd15) begin
               chr_idx_d = 5'd16;
               data_d    = 9'h0C0;
            end else begin
               chr_idx_d = chr_next;
               data_d    = {1'b1, buf_q[chr_next]};
            end
         end
         StAddr2: if (xfer) begin
            data_d = {1'b1, buf_q[16]};
         end
         StLine2: if (xfer) begin
            chr_idx_d = chr_next;
            if (chr_idx_q == 5'd31) begin
               frame_done_d = 1'b1;
               data_d       = 9'h080;
            end else begin
               data_d = {1'b1, buf_q[chr_next]};
            end
         end
         default: ;
      endcase
   end

   assign lcd.data       = data_q;
   assign lcd.data_valid = valid_q;
   assign init_done_o    = init_done_q;
   assign frame_done_o   = frame_done_q;

endmodule

// File: tb/tb_lcd_frame_seq.sv
// Directed bench for lcd_frame_seq: table-driven init/refresh vectors plus
// hand-written power-up, POWERUP_CYCLES=1 and mid-operation reset sequences.
module tb_lcd_frame_seq;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wr_en = 1'b0;
   logic [4:0] wr_addr = '0;
   logic [7:0] wr_data = '0;
   logic       ready = 1'b0;
   logic       init_done, frame_done, init_done1, frame_done1;
   int         n_checks = 0;
   int         n_fails = 0;

   always #5 clk = ~clk;

   lcd_frame_seq_if lcd_if ();
   lcd_frame_seq_if lcd_if1 ();
   assign lcd_if.device_ready  = ready;
   assign lcd_if1.device_ready = ready;

   lcd_frame_seq #(.POWERUP_CYCLES(20)) dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .wr_en_i      (wr_en),
      .wr_addr_i    (wr_addr),
      .wr_data_i    (wr_data),
      .lcd          (lcd_if),
      .init_done_o  (init_done),
      .frame_done_o (frame_done)
   );

   lcd_frame_seq #(.POWERUP_CYCLES(1)) dut1 (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .wr_en_i      (wr_en),
      .wr_addr_i    (wr_addr),
      .wr_data_i    (wr_data),
      .lcd          (lcd_if1),
      .init_done_o  (init_done1),
      .frame_done_o (frame_done1)
   );

   typedef struct {
      logic       ready;
      logic       wr_en;
      logic [4:0] wr_addr;
      logic [7:0] wr_data;
      logic [8:0] exp_data;
      logic       exp_init_done;
      logic       exp_frame_done;
   } vec_t;

   vec_t vq[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic we, input logic [4:0] wa, input logic [7:0] wd,
                      input logic [8:0] d, input logic id, input logic fd);
      vec_t v;
      v.ready = r; v.wr_en = we; v.wr_addr = wa; v.wr_data = wd;
      v.exp_data = d; v.exp_init_done = id; v.exp_frame_done = fd;
      vq.push_back(v);
   endtask

   task automatic add_chars(input int n, input logic [8:0] d);
      for (int i = 0; i < n; i++) add(1'b1, 1'b0, 5'd0, 8'h00, d, 1'b1, 1'b0);
   endtask

   // Expects valid low for cycles first..19 after release, then 9'h038 on the 20th edge.
   task automatic powerup_check(input int first);
      for (int i = first; i <= 19; i++) begin
         @(negedge clk);
         check($sformatf("pwrup%0d valid", i), lcd_if.data_valid, 1'b0);
         check($sformatf("pwrup%0d data", i), lcd_if.data, 9'h000);
      end
      @(negedge clk);
      check("pwrup20 valid", lcd_if.data_valid, 1'b1);
      check("pwrup20 data", lcd_if.data, 9'h038);
   endtask

   initial begin
      logic [8:0] exp_init [6];
      exp_init = '{9'h038, 9'h038, 9'h00C, 9'h001, 9'h006, 9'h080};

      // Init (first word already showing), with host writes landing during INIT.
      add(1'b1, 1'b1, 5'd0,  8'h41, 9'h038, 1'b0, 1'b0);
      add(1'b1, 1'b1, 5'd31, 8'h5A, 9'h038, 1'b0, 1'b0);
      add(1'b1, 1'b0, 5'd0,  8'h00, 9'h00C, 1'b0, 1'b0);
      add(1'b1, 1'b0, 5'd0,  8'h00, 9'h001, 1'b0, 1'b0);
      add(1'b1, 1'b0, 5'd0,  8'h00, 9'h006, 1'b0, 1'b0);
      add(1'b1, 1'b0, 5'd0,  8'h00, 9'h080, 1'b1, 1'b0);
      // Pass 1, with a 10-cycle stall while 0C0 is presented.
      add_chars(1, 9'h141);
      add_chars(15, 9'h120);
      add_chars(1, 9'h0C0);
      for (int i = 0; i < 10; i++) add(1'b0, 1'b0, 5'd0, 8'h00, 9'h0C0, 1'b1, 1'b0);
      add_chars(15, 9'h120);
      add_chars(1, 9'h15A);
      add(1'b1, 1'b0, 5'd0, 8'h00, 9'h080, 1'b1, 1'b1);
      // Pass 2: write 42 to address 0 on the very edge its old byte is loaded.
      add(1'b1, 1'b1, 5'd0, 8'h42, 9'h141, 1'b1, 1'b0);
      add_chars(15, 9'h120);
      add_chars(1, 9'h0C0);
      add_chars(15, 9'h120);
      add_chars(1, 9'h15A);
      add(1'b1, 1'b0, 5'd0, 8'h00, 9'h080, 1'b1, 1'b1);
      add_chars(1, 9'h142);

      ready = 1'b1;
      repeat (2) @(negedge clk);
      check("reset data", lcd_if.data, 9'h000);
      check("reset valid", lcd_if.data_valid, 1'b0);
      check("reset init_done", init_done, 1'b0);
      check("reset frame_done", frame_done, 1'b0);
      check("reset1 valid", lcd_if1.data_valid, 1'b0);
      rst_n = 1'b1;

      @(negedge clk);
      check("pwr1 edge1 valid", lcd_if1.data_valid, 1'b1);
      check("pwr1 edge1 data", lcd_if1.data, 9'h038);
      check("pwrup1 valid", lcd_if.data_valid, 1'b0);
      powerup_check(2);

      foreach (vq[i]) begin
         ready   = vq[i].ready;
         wr_en   = vq[i].wr_en;
         wr_addr = vq[i].wr_addr;
         wr_data = vq[i].wr_data;
         @(negedge clk);
         check($sformatf("vec%0d data", i), lcd_if.data, vq[i].exp_data);
         check($sformatf("vec%0d valid", i), lcd_if.data_valid, 1'b1);
         check($sformatf("vec%0d init_done", i), init_done, vq[i].exp_init_done);
         check($sformatf("vec%0d frame_done", i), frame_done, vq[i].exp_frame_done);
      end
      wr_en = 1'b0;
      ready = 1'b1;

      // Advance into LINE2 (char index 19), then reset between clock edges.
      repeat (20) @(negedge clk);
      check("line2 data", lcd_if.data, 9'h120);
      check("line2 valid", lcd_if.data_valid, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("midrst valid", lcd_if.data_valid, 1'b0);
      check("midrst init_done", init_done, 1'b0);
      check("midrst data", lcd_if.data, 9'h000);
      check("midrst frame_done", frame_done, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      powerup_check(1);

      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check($sformatf("reinit%0d data", i), lcd_if.data, exp_init[i]);
         check($sformatf("reinit%0d init_done", i), init_done, (i == 5));
      end
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         check($sformatf("clr line1 char%0d", i), lcd_if.data, 9'h120);
      end
      @(negedge clk);
      check("clr addr2", lcd_if.data, 9'h0C0);
      for (int i = 16; i < 32; i++) begin
         @(negedge clk);
         check($sformatf("clr line2 char%0d", i), lcd_if.data, 9'h120);
      end
      @(negedge clk);
      check("clr wrap data", lcd_if.data, 9'h080);
      check("clr frame_done", frame_done, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
